qmax_ctrl: RTL

Sequencing and arbitration controller for the per-state Q-max BRAM table. It shares the table's single read port and single write port between two requesters: a lookup port used by action selection and an update port used by the Q-learning update stage. The update port performs a read-compare-conditional-write, so the table only ever holds the running maximum. As a compile-time option, the controller also initializes every entry after reset.

---
 rtl/qmax_ctrl_if.sv | 42 ++++
 rtl/qmax_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/qmax_ctrl_if.sv
// Signal bundle between qmax_ctrl, its two requesters and the Q-max table.
// slave = controller view, master = requester/table view.
interface qmax_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  o_rd_ready;
    logic                  o_rd_valid;
    logic [DATA_WIDTH-1:0] o_rd_data;

    logic                  i_upd_valid;
    logic [ADDR_WIDTH-1:0] i_upd_addr;
    logic [DATA_WIDTH-1:0] i_upd_q;
    logic                  o_upd_ready;
    logic                  o_upd_done;
    logic                  o_upd_wrote;

    logic                  o_init_done;

    logic [ADDR_WIDTH-1:0] o_tab_addr_r;
    logic [ADDR_WIDTH-1:0] o_tab_addr_w;
    logic                  o_tab_read_en;
    logic                  o_tab_write_en;
    logic [DATA_WIDTH-1:0] o_tab_data;
    logic [DATA_WIDTH-1:0] i_tab_data;

    modport slave (
        input  i_rd_req, i_rd_addr, i_upd_valid, i_upd_addr, i_upd_q, i_tab_data,
        output o_rd_ready, o_rd_valid, o_rd_data, o_upd_ready, o_upd_done, o_upd_wrote,
               o_init_done, o_tab_addr_r, o_tab_addr_w, o_tab_read_en, o_tab_write_en,
               o_tab_data
    );

    modport master (
        output i_rd_req, i_rd_addr, i_upd_valid, i_upd_addr, i_upd_q, i_tab_data,
        input  o_rd_ready, o_rd_valid, o_rd_data, o_upd_ready, o_upd_done, o_upd_wrote,
               o_init_done, o_tab_addr_r, o_tab_addr_w, o_tab_read_en, o_tab_write_en,
               o_tab_data
    );
endinterface

// File: rtl/qmax_ctrl.sv
// Q-max table controller: shares one read and one write port between a lookup and a
// read-compare-conditional-write update port. QMAX_CTRL_INIT_SWEEP_EN adds a post-reset init sweep.
module qmax_ctrl #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] QINIT      = '0
) (
    input logic        i_clk,
    input logic        i_rst_n,
    qmax_ctrl_if.slave bus
);

`ifdef QMAX_CTRL_INIT_SWEEP_EN
    typedef enum logic [2:0] {INIT, IDLE, RD_ISSUE, RD_CAPT, UPD_ISSUE, UPD_CMP} state_t;
    localparam state_t ST_RST        = INIT;
    localparam logic   INIT_DONE_RST = 1'b0;
    localparam logic [ADDR_WIDTH:0] SWEEP_END = (ADDR_WIDTH+1)'(DEPTH);
    logic [ADDR_WIDTH:0] cnt_q;
`else
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, UPD_ISSUE, UPD_CMP} state_t;
    localparam state_t ST_RST        = IDLE;
    localparam logic   INIT_DONE_RST = 1'b1;
`endif

    state_t                state_q;
    logic                  last_rd_q;
    logic                  rd_ready_q, upd_ready_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  upd_done_q, upd_wrote_q;
    logic                  init_done_q;
    logic [ADDR_WIDTH-1:0] tab_addr_r_q, tab_addr_w_q;
    logic                  tab_read_en_q, tab_write_en_q;
    logic [DATA_WIDTH-1:0] tab_data_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_q_q;

    logic offer_rd_d;
    logic upd_gt_d;

    // Ready is registered, so the port offered next cycle is picked from the requests seen now;
    // with nothing pending the offer goes to the port that was not granted last.
    always_comb begin
        offer_rd_d = bus.i_rd_req ? (!bus.i_upd_valid || !last_rd_q)
                                  : (!bus.i_upd_valid && !last_rd_q);
        upd_gt_d   = $signed(req_q_q) > $signed(bus.i_tab_data);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_RST;
            last_rd_q      <= 1'b1;
            rd_ready_q     <= 1'b0;
            upd_ready_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            upd_done_q     <= 1'b0;
            upd_wrote_q    <= 1'b0;
            init_done_q    <= INIT_DONE_RST;
            tab_addr_r_q   <= '0;
            tab_addr_w_q   <= '0;
            tab_read_en_q  <= 1'b0;
            tab_write_en_q <= 1'b0;
            tab_data_q     <= '0;
            req_addr_q     <= '0;
            req_q_q        <= '0;
`ifdef QMAX_CTRL_INIT_SWEEP_EN
            cnt_q          <= '0;
`endif
        end else begin
            rd_valid_q     <= 1'b0;
            upd_done_q     <= 1'b0;
            upd_wrote_q    <= 1'b0;
            tab_read_en_q  <= 1'b0;
            tab_write_en_q <= 1'b0;
            rd_ready_q     <= 1'b0;
            upd_ready_q    <= 1'b0;
            case (state_q)
`ifdef QMAX_CTRL_INIT_SWEEP_EN
                INIT: begin
                    if (cnt_q != SWEEP_END) begin
                        tab_write_en_q <= 1'b1;
                        tab_addr_w_q   <= cnt_q[ADDR_WIDTH-1:0];
                        tab_data_q     <= QINIT;
                        cnt_q          <= cnt_q + 1'b1;
                    end else begin
                        init_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
`endif
                IDLE: begin
                    if (rd_ready_q && bus.i_rd_req) begin
                        tab_addr_r_q  <= bus.i_rd_addr;
                        tab_read_en_q <= 1'b1;
                        last_rd_q     <= 1'b1;
                        state_q       <= RD_ISSUE;
                    end else if (upd_ready_q && bus.i_upd_valid) begin
                        req_addr_q    <= bus.i_upd_addr;
                        req_q_q       <= bus.i_upd_q;
                        tab_addr_r_q  <= bus.i_upd_addr;
                        tab_read_en_q <= 1'b1;
                        last_rd_q     <= 1'b0;
                        state_q       <= UPD_ISSUE;
                    end else begin
                        rd_ready_q  <= offer_rd_d;
                        upd_ready_q <= !offer_rd_d;
                    end
                end
                RD_ISSUE:  state_q <= RD_CAPT;
                RD_CAPT: begin
                    rd_data_q   <= bus.i_tab_data;
                    rd_valid_q  <= 1'b1;
                    rd_ready_q  <= offer_rd_d;
                    upd_ready_q <= !offer_rd_d;
                    state_q     <= IDLE;
                end
                UPD_ISSUE: state_q <= UPD_CMP;
                // Finish step: done and the conditional write are registered here so they
                // appear in the same cycle the FSM is back in IDLE and can accept again.
                UPD_CMP: begin
                    upd_done_q  <= 1'b1;
                    upd_wrote_q <= upd_gt_d;
                    if (upd_gt_d) begin
                        tab_write_en_q <= 1'b1;
                        tab_addr_w_q   <= req_addr_q;
                        tab_data_q     <= req_q_q;
                    end
                    rd_ready_q  <= offer_rd_d;
                    upd_ready_q <= !offer_rd_d;
                    state_q     <= IDLE;
                end
                default: state_q <= ST_RST;
            endcase
        end
    end

    assign bus.o_rd_ready     = rd_ready_q;
    assign bus.o_rd_valid     = rd_valid_q;
    assign bus.o_rd_data      = rd_data_q;
    assign bus.o_upd_ready    = upd_ready_q;
    assign bus.o_upd_done     = upd_done_q;
    assign bus.o_upd_wrote    = upd_wrote_q;
    assign bus.o_init_done    = init_done_q;
    assign bus.o_tab_addr_r   = tab_addr_r_q;
    assign bus.o_tab_addr_w   = tab_addr_w_q;
    assign bus.o_tab_read_en  = tab_read_en_q;
    assign bus.o_tab_write_en = tab_write_en_q;
    assign bus.o_tab_data     = tab_data_q;

endmodule
